// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types, funct3 codes and lane helpers for the load/store initiator.
// Lane placement is done on a 64-bit window so a misaligned access splits into two word beats.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic size_t size_of(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we) return !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic is_split(input size_t sz, input logic [1:0] off);
        return (sz == SZ_H && off == 2'd3) || (sz == SZ_W && off != 2'd0);
    endfunction

    function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] off,
                                           input logic beat);
        logic [7:0] mask8;
        case (sz)
            SZ_B:    mask8 = 8'h01;
            SZ_H:    mask8 = 8'h03;
            default: mask8 = 8'h0F;
        endcase
        mask8 = mask8 << off;
        return beat ? mask8[7:4] : mask8[3:0];
    endfunction

    function automatic logic [DATA_W-1:0] lane_wdata(input logic [DATA_W-1:0] wdata,
                                                     input logic [1:0] off,
                                                     input logic beat);
        logic [2*DATA_W-1:0] wd64;
        wd64 = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
        return beat ? wd64[2*DATA_W-1:DATA_W] : wd64[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Request/response bus from the MEM stage and the word-organised data memory bus.
// Request handshake: a request transfers on a rising edge where req_valid and req_ready are both 1.
interface lsu_req_if #(parameter int DM_ADDRESS = 9);
    import lsu_pkg::*;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// Memory beats are always accepted; read data returns on mem_rvalid one or more cycles later.
interface lsu_mem_if #(parameter int DM_ADDRESS = 9);
    import lsu_pkg::*;
    logic                  mem_req;
    logic                  mem_we;
    logic [DM_ADDRESS-3:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_initiator_load_extract.sv
// Combinational load result: selects the addressed bytes from the two captured words and extends them.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] buf0,
    input  logic [DATA_W-1:0] buf1,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] win;
    logic [7:0]        unused_buf1_top;

    // The top byte of the second word can never fall inside a 4-byte window.
    assign unused_buf1_top = buf1[31:24];

    always_comb begin
        win = buf0;
        case (off)
            2'd0:    win = buf0;
            2'd1:    win = {buf1[7:0],  buf0[31:8]};
            2'd2:    win = {buf1[15:0], buf0[31:16]};
            default: win = {buf1[23:0], buf0[31:24]};
        endcase
    end

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_LB:   rdata = {{24{win[7]}}, win[7:0]};
            F3_LH:   rdata = {{16{win[15]}}, win[15:0]};
            F3_LW:   rdata = win;
            F3_LBU:  rdata = {24'b0, win[7:0]};
            F3_LHU:  rdata = {16'b0, win[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, split into at most two word beats, one-cycle response.
// Every output is a flop loaded with the value it must show while the FSM is in its next state.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem,
    output state_t    dbg_state
);

    localparam int MA_W = DM_ADDRESS - 2;

    state_t                state_q, state_d;
    logic                  beat_q, beat_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  split_q, split_d;
    logic [DATA_W-1:0]     buf0_q, buf0_d;
    logic [DATA_W-1:0]     buf1_q, buf1_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [MA_W-1:0]       mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

    logic [1:0]            req_off;
    size_t                 req_size;
    logic [1:0]            off_q;
    size_t                 size_q;
    logic [DATA_W-1:0]     ext_rdata;

    assign req_off  = req.req_addr[1:0];
    assign req_size = size_of(req.req_funct3[1:0]);
    assign off_q    = addr_q[1:0];
    assign size_q   = size_of(f3_q[1:0]);

    // Capture the returning word into the slot of the beat that requested it.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (state_q == WAIT && mem.mem_rvalid) begin
            if (beat_q) buf1_d = mem.mem_rdata;
            else        buf0_d = mem.mem_rdata;
        end
    end

    // Fed from the next-cycle buffers so the final beat's data reaches the response flop directly.
    lsu_load_extract u_extract (
        .buf0   (buf0_d),
        .buf1   (buf1_d),
        .off    (off_q),
        .funct3 (f3_q),
        .rdata  (ext_rdata)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = '0;
        mem_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req.req_valid && req_ready_q) begin
                    we_d    = req.req_we;
                    f3_d    = req.req_funct3;
                    addr_d  = req.req_addr;
                    wdata_d = req.req_wdata;
                    split_d = is_split(req_size, req_off);
                    beat_d  = 1'b0;
                    if (is_illegal(req.req_we, req.req_funct3)) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req.req_we;
                        mem_addr_d  = req.req_addr[DM_ADDRESS-1:2];
                        mem_be_d    = req.req_we ? lane_be(req_size, req_off, 1'b0) : 4'b0;
                        mem_wdata_d = lane_wdata(req.req_wdata, req_off, 1'b0);
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    if (split_q && !beat_q) begin
                        beat_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q[DM_ADDRESS-1:2] + MA_W'(1);
                        mem_be_d    = lane_be(size_q, off_q, 1'b1);
                        mem_wdata_d = lane_wdata(wdata_q, off_q, 1'b1);
                    end else begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    if (split_q && !beat_q) begin
                        beat_d      = 1'b1;
                        state_d     = ISSUE;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = addr_q[DM_ADDRESS-1:2] + MA_W'(1);
                        mem_wdata_d = lane_wdata(wdata_q, off_q, 1'b1);
                    end else begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ext_rdata;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            split_q     <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req.req_ready = req_ready_q;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_rdata = rsp_rdata_q;
    assign req.rsp_err   = rsp_err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: word memory model with programmable read latency,
// beat log compared against an expected-beat queue, hand-computed response values.
module tb_lsu_mem_initiator;
    import lsu_pkg::*;

    localparam int BW = 44;   // {we, addr[6:0], be[3:0], wdata[31:0]}

    logic   clk;
    logic   reset;
    state_t dbg_state;

    lsu_req_if #(.DM_ADDRESS(9)) req_bus ();
    lsu_mem_if #(.DM_ADDRESS(9)) mem_bus ();

    lsu_mem_initiator #(.DM_ADDRESS(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req_bus),
        .mem       (mem_bus),
        .dbg_state (dbg_state)
    );

    // Golden extractor instance, checked directly against hand values.
    logic [31:0] x_b0, x_b1, x_r;
    logic [1:0]  x_off;
    logic [2:0]  x_f3;
    lsu_load_extract u_gold (.buf0(x_b0), .buf1(x_b1), .off(x_off), .funct3(x_f3), .rdata(x_r));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] beat_q[$];
    int            lat = 1;
    int            rsp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] bt(input logic we, input logic [6:0] a,
                                         input logic [3:0] be, input logic [31:0] wd);
        return {we, a, be, wd};
    endfunction

    // ---------------- memory model + monitor ----------------
    initial begin
        logic [31:0] mem_arr [0:127];
        int          rd_cnt;
        logic [6:0]  rd_addr;
        for (int i = 0; i < 128; i++) mem_arr[i] = 32'h0;
        mem_arr[5]   = 32'hDDCCBBAA;
        mem_arr[6]   = 32'h44332211;
        mem_arr[127] = 32'h87654321;
        mem_arr[0]   = 32'h0FEDCBA9;
        rd_cnt  = 0;
        rd_addr = '0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_bus.mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata  = mem_arr[rd_addr];
                end
            end
            if (mem_bus.mem_req) begin
                beat_q.push_back(bt(mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata));
                if (mem_bus.mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_bus.mem_be[b]) mem_arr[mem_bus.mem_addr][8*b +: 8] = mem_bus.mem_wdata[8*b +: 8];
                end else begin
                    rd_cnt  = lat;
                    rd_addr = mem_bus.mem_addr;
                end
            end
            if (req_bus.rsp_valid) rsp_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int            n;
        bit            got;
        logic [BW-1:0] e;
        logic [BW-1:0] a;
        chk({tag, "_ready"}, req_bus.req_ready, 1'b1);
        req_bus.req_valid  = 1'b1;
        req_bus.req_we     = we;
        req_bus.req_funct3 = f3;
        req_bus.req_addr   = addr;
        req_bus.req_wdata  = wdata;
        n   = 0;
        got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            req_bus.req_valid = 1'b0;
            n++;
            if (req_bus.rsp_valid) got = 1;
        end
        chk({tag, "_lat"}, got ? n : 999, exp_lat);
        chk({tag, "_rdata"}, req_bus.rsp_rdata, exp_rdata);
        chk({tag, "_err"}, req_bus.rsp_err, exp_err);
        chk({tag, "_nbeats"}, beat_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (beat_q.size() > 0) ? beat_q.pop_front() : '1;
            chk({tag, "_beat"}, a, e);
        end
        beat_q.delete();
        @(negedge clk);
        chk({tag, "_pulse"}, req_bus.rsp_valid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int snap;
        reset = 1'b1;
        req_bus.req_valid  = 1'b0;
        req_bus.req_we     = 1'b0;
        req_bus.req_funct3 = '0;
        req_bus.req_addr   = '0;
        req_bus.req_wdata  = '0;
        x_b0 = 32'hDDCCBBAA; x_b1 = 32'h44332211; x_off = 2'd0; x_f3 = F3_LW;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_bus.req_ready, 1'b1);
        chk("rst_rsp_valid", req_bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", req_bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", req_bus.rsp_err, 1'b0);
        chk("rst_mem_req", mem_bus.mem_req, 1'b0);
        chk("rst_mem_we", mem_bus.mem_we, 1'b0);
        chk("rst_mem_be", mem_bus.mem_be, 4'b0);
        chk("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
        chk("rst_state", dbg_state, IDLE);
        reset = 1'b0;
        @(negedge clk);

        x_off = 2'd2; x_f3 = F3_LW;  #1 chk("gold_lw2", x_r, 32'h2211DDCC);
        x_off = 2'd1; x_f3 = F3_LB;  #1 chk("gold_lb1", x_r, 32'hFFFFFFBB);
        x_off = 2'd3; x_f3 = F3_LHU; #1 chk("gold_lhu3", x_r, 32'h000011DD);
        @(negedge clk);

        // Aligned word store
        lat = 1;
        exp_q.push_back(bt(1'b1, 7'd4, 4'b1111, 32'h11223344));
        do_req("sw_aligned", 1'b1, F3_SW, 9'h010, 32'h11223344, 32'h0, 1'b0, 2);

        // Byte store to lane 3, upper rs2 bits must not leak
        exp_q.push_back(bt(1'b1, 7'd4, 4'b1000, 32'hAB000000));
        do_req("sb_lane3", 1'b1, F3_SB, 9'h013, 32'hCAFE12AB, 32'h0, 1'b0, 2);

        exp_q.push_back(bt(1'b0, 7'd4, 4'b0000, 32'h0));
        do_req("lb_lane3", 1'b0, F3_LB, 9'h013, 32'h0, 32'hFFFFFFAB, 1'b0, 3);
        exp_q.push_back(bt(1'b0, 7'd4, 4'b0000, 32'h0));
        do_req("lbu_lane3", 1'b0, F3_LBU, 9'h013, 32'h0, 32'h000000AB, 1'b0, 3);
        exp_q.push_back(bt(1'b0, 7'd4, 4'b0000, 32'h0));
        do_req("lh_lane2", 1'b0, F3_LH, 9'h012, 32'h0, 32'hFFFFAB22, 1'b0, 3);
        exp_q.push_back(bt(1'b0, 7'd4, 4'b0000, 32'h0));
        do_req("lhu_lane2", 1'b0, F3_LHU, 9'h012, 32'h0, 32'h0000AB22, 1'b0, 3);

        // Split word load with two-cycle memory latency
        lat = 2;
        exp_q.push_back(bt(1'b0, 7'd5, 4'b0000, 32'h0));
        exp_q.push_back(bt(1'b0, 7'd6, 4'b0000, 32'h0));
        do_req("lw_split", 1'b0, F3_LW, 9'h016, 32'h0, 32'h2211DDCC, 1'b0, 7);

        // Split halfword store and read-back
        lat = 1;
        exp_q.push_back(bt(1'b1, 7'd7, 4'b1000, 32'hEF000000));
        exp_q.push_back(bt(1'b1, 7'd8, 4'b0001, 32'h000000BE));
        do_req("sh_split", 1'b1, F3_SH, 9'h01F, 32'h0000BEEF, 32'h0, 1'b0, 3);
        exp_q.push_back(bt(1'b0, 7'd7, 4'b0000, 32'h0));
        exp_q.push_back(bt(1'b0, 7'd8, 4'b0000, 32'h0));
        do_req("lh_split", 1'b0, F3_LH, 9'h01F, 32'h0, 32'hFFFFBEEF, 1'b0, 5);

        // Split word store at offset 1 and read-back
        exp_q.push_back(bt(1'b1, 7'd8, 4'b1110, 32'hB2C3D400));
        exp_q.push_back(bt(1'b1, 7'd9, 4'b0001, 32'h000000A1));
        do_req("sw_split", 1'b1, F3_SW, 9'h021, 32'hA1B2C3D4, 32'h0, 1'b0, 3);
        exp_q.push_back(bt(1'b0, 7'd8, 4'b0000, 32'h0));
        exp_q.push_back(bt(1'b0, 7'd9, 4'b0000, 32'h0));
        do_req("lw_split1", 1'b0, F3_LW, 9'h021, 32'h0, 32'hA1B2C3D4, 1'b0, 5);

        // Word index wrap at the top of memory
        exp_q.push_back(bt(1'b0, 7'd127, 4'b0000, 32'h0));
        exp_q.push_back(bt(1'b0, 7'd0, 4'b0000, 32'h0));
        do_req("lw_wrap", 1'b0, F3_LW, 9'h1FE, 32'h0, 32'hCBA98765, 1'b0, 5);

        // Illegal encodings: no beat, error after one cycle
        do_req("ld_illegal", 1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1, 1);
        do_req("st_illegal", 1'b1, 3'b100, 9'h010, 32'h12345678, 32'h0, 1'b1, 1);

        // Reset while waiting on a slow read
        lat  = 6;
        snap = rsp_cnt;
        req_bus.req_valid  = 1'b1;
        req_bus.req_we     = 1'b0;
        req_bus.req_funct3 = F3_LW;
        req_bus.req_addr   = 9'h010;
        req_bus.req_wdata  = '0;
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_wait", dbg_state, WAIT);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_state", dbg_state, IDLE);
        chk("abort_ready", req_bus.req_ready, 1'b1);
        chk("abort_mem_req", mem_bus.mem_req, 1'b0);
        repeat (10) @(negedge clk);
        chk("abort_state_late", dbg_state, IDLE);
        chk("abort_no_rsp", rsp_cnt, snap);
        chk("abort_nbeats", beat_q.size(), 1);
        if (beat_q.size() > 0) chk("abort_beat", beat_q[0], bt(1'b0, 7'd4, 4'b0000, 32'h0));
        beat_q.delete();

        // Normal operation resumes after the abort
        lat = 1;
        exp_q.push_back(bt(1'b0, 7'd4, 4'b0000, 32'h0));
        do_req("lw_after_abort", 1'b0, F3_LW, 9'h010, 32'h0, 32'hAB223344, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
